// File: rtl/pcie_msi_pkg.sv
// pcie_msi_pkg: shared constants and FSM encoding for the MSI responder
package pcie_msi_pkg;
  localparam int MSI_VEC_W = 5;
  localparam int MSI_FUNC_W = 4;
  localparam int MMENABLE_MAX = 5;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, FAIL} msi_state_t;
endpackage

// File: rtl/msi_vec_encode.sv
// msi_vec_encode: one-hot check and binary encode of a 32-bit MSI request
module msi_vec_encode
  import pcie_msi_pkg::*;
(
  input  logic [31:0]          vec,
  output logic                 one_hot,
  output logic [MSI_VEC_W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < 32; i++) idx = idx | (vec[i] ? i[MSI_VEC_W-1:0] : '0);
  end
  assign one_hot = (vec != '0) && ((vec & (vec - 32'd1)) == '0);
endmodule

// File: rtl/pcie_us_msi_responder.sv
// pcie_us_msi_responder: hard-IP side of the cfg_interrupt_msi interface,
// validates requests, issues descriptors and answers with sent/fail pulses
module pcie_us_msi_responder
  import pcie_msi_pkg::*;
#(
  parameter int FUNC_COUNT = 4,
  parameter int SENT_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             cfg_interrupt_msi_int,
  input  logic [3:0]              cfg_interrupt_msi_function_number,
  input  logic [2:0]              cfg_interrupt_msi_attr,
  output logic                    cfg_interrupt_msi_sent,
  output logic                    cfg_interrupt_msi_fail,
  input  logic [31:0]             cfg_interrupt_msi_pending_status,
  input  logic                    cfg_interrupt_msi_pending_status_data_enable,
  input  logic [3:0]              cfg_interrupt_msi_pending_status_function_num,
  input  logic [FUNC_COUNT-1:0]   msi_enable,
  input  logic [3*FUNC_COUNT-1:0] msi_mmenable,
  input  logic [32*FUNC_COUNT-1:0] msi_mask,
  input  logic [16*FUNC_COUNT-1:0] msi_data_base,
  output logic [31:0]             m_msi_data,
  output logic [3:0]              m_msi_func,
  output logic [2:0]              m_msi_attr,
  output logic                    m_msi_valid,
  input  logic                    m_msi_ready,
  output logic [32*FUNC_COUNT-1:0] msi_pending,
  output logic                    err_overrun
);
  msi_state_t state;
  logic oh_d, oh_q, f_ok, en_f, v_ok, masked, chk_fail, set_pend, sent_set;
  logic [MSI_VEC_W-1:0] vec_d, vec_q;
  logic [MSI_FUNC_W-1:0] func_q;
  logic [2:0] attr_q, mm_f;
  logic [3:0] cnt;
  logic [31:0] mask_f, vec_bit;
  logic [15:0] base_f, low_m;
  logic [32*FUNC_COUNT-1:0] pend_d;
  msi_vec_encode u_enc (.vec(cfg_interrupt_msi_int), .one_hot(oh_d), .idx(vec_d));
  always_comb begin
    f_ok = 1'b0;
    en_f = 1'b0;
    mm_f = '0;
    mask_f = '0;
    base_f = '0;
    for (int i = 0; i < FUNC_COUNT; i++)
      if (func_q == i[MSI_FUNC_W-1:0]) begin
        f_ok = 1'b1;
        en_f = msi_enable[i];
        mm_f = msi_mmenable[3*i +: 3] > 3'(MMENABLE_MAX) ? 3'(MMENABLE_MAX) : msi_mmenable[3*i +: 3];
        mask_f = msi_mask[32*i +: 32];
        base_f = msi_data_base[16*i +: 16];
      end
  end
  assign low_m = ~(16'hFFFF << mm_f);
  assign vec_bit = 32'd1 << vec_q;
  assign v_ok = (vec_q >> mm_f) == '0;
  assign masked = mask_f[vec_q];
  assign chk_fail = !oh_q || !f_ok || !en_f || !v_ok || masked;
  assign set_pend = state == CHECK && oh_q && f_ok && en_f && v_ok && masked;
  assign sent_set = (state == ISSUE && m_msi_ready && SENT_DELAY == 1) || (state == WAIT && cnt == 4'd1);
  // Order gives write-over-clear and write-OR-set when they hit the same bit
  always_comb begin
    pend_d = msi_pending;
    for (int i = 0; i < FUNC_COUNT; i++) begin
      if (sent_set && func_q == i[MSI_FUNC_W-1:0]) pend_d[32*i +: 32] = pend_d[32*i +: 32] & ~vec_bit;
      if (cfg_interrupt_msi_pending_status_data_enable && cfg_interrupt_msi_pending_status_function_num == i[MSI_FUNC_W-1:0])
        pend_d[32*i +: 32] = cfg_interrupt_msi_pending_status;
      if (set_pend && func_q == i[MSI_FUNC_W-1:0]) pend_d[32*i +: 32] = pend_d[32*i +: 32] | vec_bit;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      oh_q <= 1'b0;
      vec_q <= '0;
      func_q <= '0;
      attr_q <= '0;
      cnt <= '0;
      cfg_interrupt_msi_sent <= 1'b0;
      cfg_interrupt_msi_fail <= 1'b0;
      m_msi_data <= '0;
      m_msi_func <= '0;
      m_msi_attr <= '0;
      m_msi_valid <= 1'b0;
      msi_pending <= '0;
      err_overrun <= 1'b0;
    end else begin
      msi_pending <= pend_d;
      cfg_interrupt_msi_sent <= sent_set;
      cfg_interrupt_msi_fail <= 1'b0;
      if (state != IDLE && cfg_interrupt_msi_int != '0) err_overrun <= 1'b1;
      case (state)
        IDLE: if (cfg_interrupt_msi_int != '0) begin
          oh_q <= oh_d;
          vec_q <= vec_d;
          func_q <= cfg_interrupt_msi_function_number;
          attr_q <= cfg_interrupt_msi_attr;
          state <= CHECK;
        end
        CHECK: if (chk_fail) begin
          cfg_interrupt_msi_fail <= 1'b1;
          state <= FAIL;
        end else begin
          m_msi_valid <= 1'b1;
          m_msi_data <= {16'h0, (base_f & ~low_m) | (16'(vec_q) & low_m)};
          m_msi_func <= func_q;
          m_msi_attr <= attr_q;
          state <= ISSUE;
        end
        ISSUE: if (m_msi_ready) begin
          m_msi_valid <= 1'b0;
          cnt <= 4'(SENT_DELAY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          if (cfg_interrupt_msi_sent) state <= IDLE;
        end
        FAIL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_us_msi_responder.sv
// tb_pcie_us_msi_responder: directed vector table plus multi-cycle corner sequences
module tb_pcie_us_msi_responder;
  localparam int FC = 4;
  localparam int SD = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] int_i = '0, pend_data = '0;
  logic [3:0] func_i = '0, pend_func = '0;
  logic [2:0] attr_i = '0;
  logic pend_en = 1'b0, ready = 1'b1;
  logic sent, fail, valid, err;
  logic [FC-1:0] msi_enable = '0;
  logic [3*FC-1:0] msi_mmenable = '0;
  logic [32*FC-1:0] msi_mask = '0;
  logic [16*FC-1:0] msi_data_base = '0;
  logic [31:0] m_data;
  logic [3:0] m_func;
  logic [2:0] m_attr;
  logic [32*FC-1:0] msi_pending;
  int total = 0, passed = 0;
  int kv, ks, kf, ns, nf, bad;
  logic [31:0] d;
  logic [3:0] fo;
  logic [2:0] ao;
  typedef struct {
    logic [31:0] iv;
    logic [3:0]  f;
    logic [2:0]  a;
    logic        en;
    logic [2:0]  mm;
    logic [15:0] base;
    logic        exp_sent;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  pcie_us_msi_responder #(.FUNC_COUNT(FC), .SENT_DELAY(SD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_interrupt_msi_int(int_i),
    .cfg_interrupt_msi_function_number(func_i),
    .cfg_interrupt_msi_attr(attr_i),
    .cfg_interrupt_msi_sent(sent),
    .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_pending_status(pend_data),
    .cfg_interrupt_msi_pending_status_data_enable(pend_en),
    .cfg_interrupt_msi_pending_status_function_num(pend_func),
    .msi_enable(msi_enable),
    .msi_mmenable(msi_mmenable),
    .msi_mask(msi_mask),
    .msi_data_base(msi_data_base),
    .m_msi_data(m_data),
    .m_msi_func(m_func),
    .m_msi_attr(m_attr),
    .m_msi_valid(valid),
    .m_msi_ready(ready),
    .msi_pending(msi_pending),
    .err_overrun(err)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic setup(input logic [3:0] f, input logic en, input logic [2:0] mm, input logic [15:0] base, input logic [31:0] mask);
    int fi;
    fi = int'(f);
    msi_enable = '1;
    msi_mmenable = {FC{3'd5}};
    msi_mask = '0;
    msi_data_base = '0;
    if (fi < FC) begin
      msi_enable[fi] = en;
      msi_mmenable[3*fi +: 3] = mm;
      msi_data_base[16*fi +: 16] = base;
      msi_mask[32*fi +: 32] = mask;
    end
  endtask
  // k counts negedges after the capture edge; k=2 is the first response cycle
  task automatic req(input logic [31:0] iv, input logic [3:0] f, input logic [2:0] a, input int win,
                     output int okv, oks, okf, ons, onf, output logic [31:0] od, output logic [3:0] ofo, output logic [2:0] oao);
    okv = -1; oks = -1; okf = -1; ons = 0; onf = 0; od = '0; ofo = '0; oao = '0;
    @(negedge clk);
    int_i = iv; func_i = f; attr_i = a;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      int_i = '0;
      if (valid && okv < 0) begin okv = k; od = m_data; ofo = m_func; oao = m_attr; end
      if (sent) begin ons++; if (oks < 0) oks = k; end
      if (fail) begin onf++; if (okf < 0) okf = k; end
    end
  endtask
  initial begin
    tbl[0] = '{32'h20,       4'd0, 3'd2, 1'b1, 3'd3, 16'h4A20, 1'b1, 32'h00004A25};
    tbl[1] = '{32'h3,        4'd0, 3'd0, 1'b1, 3'd3, 16'h4A20, 1'b0, 32'h0};
    tbl[2] = '{32'h1,        4'd1, 3'd0, 1'b0, 3'd5, 16'h0,    1'b0, 32'h0};
    tbl[3] = '{32'h10,       4'd0, 3'd0, 1'b1, 3'd2, 16'h0,    1'b0, 32'h0};
    tbl[4] = '{32'h1,        4'd5, 3'd0, 1'b1, 3'd5, 16'h0,    1'b0, 32'h0};
    tbl[5] = '{32'h80000000, 4'd0, 3'd1, 1'b1, 3'd5, 16'h1234, 1'b1, 32'h0000123F};
    tbl[6] = '{32'h1,        4'd3, 3'd5, 1'b1, 3'd0, 16'hBEEF, 1'b1, 32'h0000BEEF};
    tbl[7] = '{32'h2,        4'd3, 3'd0, 1'b1, 3'd0, 16'hBEEF, 1'b0, 32'h0};
    tbl[8] = '{32'h2,        4'd2, 3'd7, 1'b1, 3'd1, 16'h0,    1'b1, 32'h00000001};
    repeat (3) @(negedge clk);
    chk("rst_sent", sent, 0);
    chk("rst_fail", fail, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_err", err, 0);
    chk("rst_pending", msi_pending == '0, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      setup(tbl[i].f, tbl[i].en, tbl[i].mm, tbl[i].base, 32'h0);
      req(tbl[i].iv, tbl[i].f, tbl[i].a, 12, kv, ks, kf, ns, nf, d, fo, ao);
      chk($sformatf("v%0d_sent_n", i), ns, tbl[i].exp_sent ? 1 : 0);
      chk($sformatf("v%0d_fail_n", i), nf, tbl[i].exp_sent ? 0 : 1);
      if (tbl[i].exp_sent) begin
        chk($sformatf("v%0d_valid_t", i), kv, 2);
        chk($sformatf("v%0d_sent_t", i), ks, 2 + SD);
        chk($sformatf("v%0d_data", i), d, tbl[i].exp_data);
        chk($sformatf("v%0d_func", i), fo, tbl[i].f);
        chk($sformatf("v%0d_attr", i), ao, tbl[i].a);
      end else begin
        chk($sformatf("v%0d_fail_t", i), kf, 2);
        chk($sformatf("v%0d_no_valid", i), kv, -1);
      end
    end
    // masked vector records pending, unmask and re-request clears it
    setup(4'd0, 1'b1, 3'd3, 16'h4A20, 32'h8);
    req(32'h8, 4'd0, 3'd0, 12, kv, ks, kf, ns, nf, d, fo, ao);
    chk("mask_fail_n", nf, 1);
    chk("mask_fail_t", kf, 2);
    chk("mask_no_valid", kv, -1);
    chk("mask_pending", msi_pending[31:0], 32'h8);
    setup(4'd0, 1'b1, 3'd3, 16'h4A20, 32'h0);
    req(32'h8, 4'd0, 3'd0, 12, kv, ks, kf, ns, nf, d, fo, ao);
    chk("unmask_sent_n", ns, 1);
    chk("unmask_data", d, 32'h00004A23);
    chk("unmask_pending", msi_pending[31:0], 32'h0);
    // stalled descriptor with an overrun request in the middle
    setup(4'd0, 1'b1, 3'd3, 16'h4A20, 32'h0);
    ready = 1'b0;
    bad = 0;
    @(negedge clk);
    int_i = 32'h20; func_i = 4'd0; attr_i = 3'd4;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      int_i = (k == 5) ? 32'h1 : 32'h0;
      if (k >= 2 && !(valid && m_data == 32'h00004A25 && m_attr == 3'd4)) bad++;
      if (sent || fail) bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_overrun", err, 1);
    ready = 1'b1;
    ns = 0; nf = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sent) ns++;
      if (fail) nf++;
    end
    chk("stall_sent_n", ns, 1);
    chk("stall_fail_n", nf, 0);
    chk("stall_valid_drop", valid, 0);
    // pending write coinciding with a mask-set on the same function
    setup(4'd2, 1'b1, 3'd3, 16'h0, 32'h2);
    @(negedge clk);
    int_i = 32'h2; func_i = 4'd2;
    @(negedge clk);
    int_i = '0;
    pend_en = 1'b1; pend_func = 4'd2; pend_data = 32'hFFFF0000;
    @(negedge clk);
    pend_en = 1'b0;
    chk("wr_or_set", msi_pending[95:64], 32'hFFFF0002);
    chk("wr_or_fail", fail, 1);
    pend_en = 1'b1; pend_func = 4'd5; pend_data = 32'hFFFFFFFF;
    @(negedge clk);
    pend_en = 1'b0;
    chk("wr_drop", msi_pending == {32'h0, 32'hFFFF0002, 64'h0}, 1);
    repeat (4) @(negedge clk);
    // reset while waiting for the sent pulse
    setup(4'd0, 1'b1, 3'd3, 16'h4A20, 32'h0);
    @(negedge clk);
    int_i = 32'h20; func_i = 4'd0; attr_i = 3'd0;
    repeat (3) begin @(negedge clk); int_i = '0; end
    rst_n = 1'b0;
    #1;
    chk("wrst_valid", valid, 0);
    chk("wrst_data", m_data, 0);
    chk("wrst_err", err, 0);
    chk("wrst_pending", msi_pending == '0, 1);
    ns = 0; nf = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (sent) ns++;
      if (fail) nf++;
    end
    chk("wrst_no_pulse", ns + nf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    req(32'h20, 4'd0, 3'd0, 12, kv, ks, kf, ns, nf, d, fo, ao);
    chk("post_rst_sent_n", ns, 1);
    chk("post_rst_sent_t", ks, 2 + SD);
    chk("post_rst_data", d, 32'h00004A25);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
